// File: rtl/router_pkg.sv
// Shared router types: default port count, owner-index width and allocator FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

    localparam int N    = 4;
    localparam int IDXW = 2;

    typedef logic [IDXW-1:0] port_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req at or after base, in circular order.
// Latency: purely combinational.
// Backpressure: none; the result is only a suggestion the caller may ignore.
module rr_pick #(
    parameter int N    = router_pkg::N,
    parameter int IDXW = router_pkg::IDXW
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] base,
    output logic [N-1:0]    onehot,
    output logic            found
);

    // Walk the N positions starting at base and keep only the first requester.
    always_comb begin
        logic [IDXW-1:0] idx;
        onehot = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDXW'((int'(base) + k) % N);
            if (!found && req[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_alloc.sv
// Output-port allocator: round-robin grant locked to one input for a whole packet (head..tail).
// Latency: grant appears one cycle after request; back-to-back packets re-grant with no idle bubble.
// Backpressure: out_ready=0 or a dropped owner request stalls the packet in place; no preemption, no timeout.
module out_port_alloc #(
    parameter int N    = router_pkg::N,
    parameter int IDXW = router_pkg::IDXW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    tail,
    input  logic            out_ready,
    output logic [N-1:0]    gnt,
    output logic            xfer,
    output logic            busy,
    output logic [IDXW-1:0] owner,
    output logic [15:0]     flit_cnt
);

    import router_pkg::*;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] owner_next;
    logic [IDXW-1:0] base;
    logic [N-1:0]    pick_oh;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            tail_xfer;

    // While locked the search starts just past the owner, so the finishing input ranks last.
    always_comb begin
        owner_next = (owner == IDXW'(N - 1)) ? '0 : owner + IDXW'(1);
        base       = (state == LOCKED) ? owner_next : ptr;
        xfer       = (|(gnt & req)) & out_ready;
        tail_xfer  = xfer & tail[owner];
        busy       = (state == LOCKED);
    end

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .base   (base),
        .onehot (pick_oh),
        .found  (pick_found)
    );

    // Encode the one-hot pick into an owner index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                pick_idx = IDXW'(i);
            end
        end
    end

    // Allocation FSM: grant on request, hold through the packet, re-grant or release on tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && pick_found) begin
                        gnt   <= pick_oh;
                        owner <= pick_idx;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (tail_xfer) begin
                        ptr <= owner_next;
                        if (en && pick_found) begin
                            gnt   <= pick_oh;
                            owner <= pick_idx;
                        end else begin
                            gnt   <= '0;
                            owner <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    owner <= '0;
                end
            endcase
        end
    end

    // Free-running count of flits sent downstream; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flit_cnt <= '0;
        end else if (xfer) begin
            flit_cnt <= flit_cnt + 16'd1;
        end
    end

endmodule

// File: doc/out_port_alloc.md
OUT_PORT_ALLOC -- requirements
Module: out_port_alloc

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of requesting input ports.
REQ-002 SHALL have parameter IDXW, default 2, meaning the owner index width, equal to clog2(N).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port en  in  1  arbitration enable; 0 blocks new grants only.
REQ-006 SHALL have port req  in  N  per-input flit-valid, held until transferred.
REQ-007 SHALL have port tail  in  N  per-input tail flag of the presented flit.
REQ-008 SHALL have port out_ready  in  1  downstream buffer can accept a flit this cycle.
REQ-009 SHALL have port gnt  out  N  registered one-hot grant, or all-zero.
REQ-010 SHALL have port xfer  out  1  combinational flit transfer: |(gnt & req) & out_ready.
REQ-011 SHALL have port busy  out  1  state is LOCKED.
REQ-012 SHALL have port owner  out  IDXW  index of the granted input; 0 when idle.
REQ-013 SHALL have port flit_cnt  out  16  count of transferred flits, wrapping from 0xFFFF to 0.

Function
REQ-014 SHALL implement FSM states IDLE and LOCKED, with a round-robin pointer ptr (IDXW bits).
REQ-015 IDLE, when en=1 and |req=1: SHALL pick the first requester at or after ptr in circular order, load gnt/owner at the next edge, and go to LOCKED (latency 1 cycle from req to gnt).
REQ-016 IDLE, when en=0 or req=0: SHALL hold gnt=0 and keep ptr unchanged.
REQ-017 LOCKED: SHALL hold gnt=onehot(owner) across multiple flits until a tail flit transfers; a request from any other input SHALL NOT preempt it.
REQ-018 LOCKED, when req[owner]=0 or out_ready=0: xfer SHALL be 0 and state SHALL hold (stall, no timeout).
REQ-019 A transfer with tail[owner]=1 SHALL set ptr=owner+1 modulo N at that edge.
REQ-020 On a tail transfer with en=1 and |req=1, the next cycle SHALL grant the first requester at or after owner+1, without an idle bubble and staying LOCKED; the old owner has lowest priority.
REQ-021 On a tail transfer with en=0 or no requests: SHALL set gnt=0 and go to IDLE.
REQ-022 en=0 while LOCKED: SHALL let the current packet finish; a re-grant SHALL be suppressed per REQ-021.
REQ-023 A single-flit packet (head=tail) SHALL occupy exactly one LOCKED cycle when out_ready=1.
REQ-024 flit_cnt SHALL increment by 1 on every cycle with xfer=1.
REQ-025 tail is ignored unless gnt, req and out_ready are all 1 for the same input.

Reset
REQ-026 reset=0 SHALL immediately force gnt=0, owner=0, busy=0, ptr=0, flit_cnt=0, state IDLE, including in the middle of a packet.
REQ-027 The first grant after reset deassertion SHALL favour input 0.

Structure
REQ-028 The shared package router_pkg SHALL hold N, IDXW, the port-index typedef and the FSM state enum.
REQ-029 A sub-module rr_pick SHALL perform combinational rotating-priority selection with inputs req and base index and outputs a one-hot result plus a found flag; out_port_alloc SHALL own ptr.

Verification
REQ-030 After reset, with req=4'b1111, tail=4'b1111, out_ready=1, en=1 -> gnt SHALL be 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no bubbles.
REQ-031 With req0 sending a 3-flit packet (tail on flit 3) and req2 asserted from cycle 1 -> gnt=0001 for 3 transfers, then 0100; no preemption.
REQ-032 With owner=1 and out_ready=0 for 4 cycles mid-packet -> xfer=0 and gnt=0010 held; flit_cnt unchanged.
REQ-033 With en=0 and req=1111 -> gnt=0 for 3 cycles; setting en=1 -> gnt=0001 one cycle later; with en=0 asserted mid-packet, the packet completes and then gnt=0.
REQ-034 With reset=0 applied mid-packet at owner=2 -> gnt=0 without waiting for a clock edge; after release with req=1111 -> gnt=0001.
REQ-035 After 65536 single-flit transfers -> flit_cnt wraps to 0.
